// File: rtl/gfx_fb_write_arb_if.sv
// -----------------------------------------------------------------------------
// gfx_fb_write_arb_if
// Bundles every non-clock/reset signal of the framebuffer write arbiter:
//   - clear control : clear_req (in), clear_busy / clear_done (out)
//   - clear source  : clr_x/clr_y/clr_color/clr_valid/clr_last (in),
//                     clr_reset / clr_inc (out)
//   - draw source   : draw_x/draw_y/draw_color/draw_valid (in), draw_ready (out)
//   - fb write port : fb_x/fb_y/fb_color/fb_valid (out), fb_ready (in)
// Modports:
//   slave  - the arbiter's view (directions as listed above)
//   master - the surrounding environment's view (directions reversed)
// -----------------------------------------------------------------------------
interface gfx_fb_write_arb_if #(
    parameter int FB_WIDTH   = 640,
    parameter int FB_HEIGHT  = 480,
    parameter int PIXEL_BITS = 12
);
    localparam int FB_X_BITS = $clog2(FB_WIDTH);
    localparam int FB_Y_BITS = $clog2(FB_HEIGHT);

    logic                  clear_req;
    logic                  clear_busy;
    logic                  clear_done;
    logic                  clr_reset;
    logic                  clr_inc;
    logic [FB_X_BITS-1:0]  clr_x;
    logic [FB_Y_BITS-1:0]  clr_y;
    logic [PIXEL_BITS-1:0] clr_color;
    logic                  clr_valid;
    logic                  clr_last;
    logic                  draw_valid;
    logic                  draw_ready;
    logic [FB_X_BITS-1:0]  draw_x;
    logic [FB_Y_BITS-1:0]  draw_y;
    logic [PIXEL_BITS-1:0] draw_color;
    logic                  fb_valid;
    logic                  fb_ready;
    logic [FB_X_BITS-1:0]  fb_x;
    logic [FB_Y_BITS-1:0]  fb_y;
    logic [PIXEL_BITS-1:0] fb_color;

    modport slave (
        input  clear_req, clr_x, clr_y, clr_color, clr_valid, clr_last,
               draw_valid, draw_x, draw_y, draw_color, fb_ready,
        output clear_busy, clear_done, clr_reset, clr_inc, draw_ready,
               fb_valid, fb_x, fb_y, fb_color
    );

    modport master (
        output clear_req, clr_x, clr_y, clr_color, clr_valid, clr_last,
               draw_valid, draw_x, draw_y, draw_color, fb_ready,
        input  clear_busy, clear_done, clr_reset, clr_inc, draw_ready,
               fb_valid, fb_x, fb_y, fb_color
    );
endinterface

// File: rtl/gfx_fb_write_arb.sv
// -----------------------------------------------------------------------------
// gfx_fb_write_arb
// Shares the single framebuffer pixel-write port between the draw pipeline and
// the framebuffer clear generator. A clear request stalls the draw stream,
// resets and restarts the clear generator, forwards every clear pixel and then
// hands the port back to the draw stream. The output is a one-entry registered
// stage with valid/ready backpressure.
//
// Ports:
//   clk   - clock
//   reset - synchronous, active-high reset
//   bus   - gfx_fb_write_arb_if.slave (clear control, clear source, draw
//           source and framebuffer write port)
//
// Build option:
//   GFX_FB_ARB_CLEAR_ON_RESET_EN - when defined the reset state is CLR_RST, so
//   a full clear runs automatically after reset. When undefined the reset
//   state is DRAW and clears happen only on clear_req.
// -----------------------------------------------------------------------------
module gfx_fb_write_arb #(
    parameter int FB_WIDTH   = 640,
    parameter int FB_HEIGHT  = 480,
    parameter int PIXEL_BITS = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    gfx_fb_write_arb_if.slave      bus
);
    localparam int FB_X_BITS = $clog2(FB_WIDTH);
    localparam int FB_Y_BITS = $clog2(FB_HEIGHT);

    localparam logic [1:0] ST_DRAW    = 2'd0;
    localparam logic [1:0] ST_CLR_RST = 2'd1;
    localparam logic [1:0] ST_CLR_RUN = 2'd2;

`ifdef GFX_FB_ARB_CLEAR_ON_RESET_EN
    localparam logic [1:0] ST_RESET = ST_CLR_RST;
`else
    localparam logic [1:0] ST_RESET = ST_DRAW;
`endif

    logic [1:0]            state_q,    state_d;
    logic                  pending_q,  pending_d;
    // Blocks the first CLR_RUN cycle: the generator output seen there may
    // still be stale from before its reset.
    logic                  skip_q,     skip_d;
    logic                  fb_valid_q, fb_valid_d;
    logic [FB_X_BITS-1:0]  fb_x_q,     fb_x_d;
    logic [FB_Y_BITS-1:0]  fb_y_q,     fb_y_d;
    logic [PIXEL_BITS-1:0] fb_color_q, fb_color_d;

    logic load_s;
    logic draw_ready_s;
    logic draw_xfer_s;
    logic clr_xfer_s;
    logic clear_done_s;

    // Handshake decode: which source (if any) moves into the output stage.
    always_comb begin
        load_s       = !fb_valid_q || bus.fb_ready;
        draw_ready_s = (state_q == ST_DRAW) && load_s && !pending_q && !bus.clear_req;
        draw_xfer_s  = draw_ready_s && bus.draw_valid;
        clr_xfer_s   = (state_q == ST_CLR_RUN) && !skip_q && bus.clr_valid && load_s;
        clear_done_s = clr_xfer_s && bus.clr_last;
    end

    // Sequencer next state: DRAW -> (pending) -> CLR_RST -> CLR_RUN -> DRAW.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        skip_d    = 1'b0;
        case (state_q)
            ST_DRAW: begin
                if (pending_q) begin
                    state_d = ST_CLR_RST;
                end else if (bus.clear_req) begin
                    pending_d = 1'b1;
                end else begin
                    pending_d = pending_q;
                end
            end
            ST_CLR_RST: begin
                pending_d = 1'b0;
                skip_d    = 1'b1;
                state_d   = ST_CLR_RUN;
            end
            ST_CLR_RUN: begin
                // clear_req is ignored here; it is not queued.
                if (clear_done_s) begin
                    state_d = ST_DRAW;
                end else begin
                    state_d = ST_CLR_RUN;
                end
            end
            default: begin
                state_d   = ST_DRAW;
                pending_d = 1'b0;
            end
        endcase
    end

    // Output stage next value: load the selected source or drain to empty.
    always_comb begin
        fb_valid_d = fb_valid_q;
        fb_x_d     = fb_x_q;
        fb_y_d     = fb_y_q;
        fb_color_d = fb_color_q;
        if (load_s) begin
            if (draw_xfer_s) begin
                fb_valid_d = 1'b1;
                fb_x_d     = bus.draw_x;
                fb_y_d     = bus.draw_y;
                fb_color_d = bus.draw_color;
            end else if (clr_xfer_s) begin
                fb_valid_d = 1'b1;
                fb_x_d     = bus.clr_x;
                fb_y_d     = bus.clr_y;
                fb_color_d = bus.clr_color;
            end else begin
                fb_valid_d = 1'b0;
            end
        end else begin
            fb_valid_d = fb_valid_q;
        end
    end

    // State and output-stage registers; reset drops any buffered pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RESET;
            pending_q  <= 1'b0;
            skip_q     <= 1'b0;
            fb_valid_q <= 1'b0;
            fb_x_q     <= {FB_X_BITS{1'b0}};
            fb_y_q     <= {FB_Y_BITS{1'b0}};
            fb_color_q <= {PIXEL_BITS{1'b0}};
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            skip_q     <= skip_d;
            fb_valid_q <= fb_valid_d;
            fb_x_q     <= fb_x_d;
            fb_y_q     <= fb_y_d;
            fb_color_q <= fb_color_d;
        end
    end

    assign bus.clear_busy = (state_q != ST_DRAW);
    assign bus.clear_done = clear_done_s;
    assign bus.clr_reset  = (state_q == ST_CLR_RST);
    assign bus.clr_inc    = clr_xfer_s;
    assign bus.draw_ready = draw_ready_s;
    assign bus.fb_valid   = fb_valid_q;
    assign bus.fb_x       = fb_x_q;
    assign bus.fb_y       = fb_y_q;
    assign bus.fb_color   = fb_color_q;

endmodule

// File: tb/tb_gfx_fb_write_arb.sv
// -----------------------------------------------------------------------------
// tb_gfx_fb_write_arb
// Bench for gfx_fb_write_arb with a 4x2 framebuffer and a behavioural clear
// generator. The reference model is an ordered queue of expected output
// pixels: accepted draw pixels are appended as they are handed over, and an
// honoured clear request appends the whole raster of clear pixels at once.
// -----------------------------------------------------------------------------
module tb_gfx_fb_write_arb;
    localparam int W  = 4;
    localparam int H  = 2;
    localparam int PB = 12;
    localparam int XB = $clog2(W);
    localparam int YB = $clog2(H);
    localparam int NPIX = W * H;

`ifdef GFX_FB_ARB_CLEAR_ON_RESET_EN
    localparam bit AUTO_CLR = 1'b1;
`else
    localparam bit AUTO_CLR = 1'b0;
`endif

    typedef struct {
        logic [XB+YB+PB-1:0] pix;
        bit                  clr;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gfx_fb_write_arb_if #(.FB_WIDTH(W), .FB_HEIGHT(H), .PIXEL_BITS(PB)) bus();

    gfx_fb_write_arb #(.FB_WIDTH(W), .FB_HEIGHT(H), .PIXEL_BITS(PB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    exp_t    exp_q[$];
    exp_t    e_m;
    int      total = 0;
    int      bad = 0;
    int      clr_out = 0;
    int      done_cnt = 0;
    int      rst_cnt = 0;
    logic [PB-1:0] clr_col_v;
    logic          gen_valid_v;
    logic [XB-1:0] gx;
    logic [YB-1:0] gy;

    // Behavioural clear generator: raster walk restarted by clr_reset.
    always @(posedge clk) begin
        if (bus.clr_reset) begin
            gx <= '0;
            gy <= '0;
        end else if (bus.clr_inc) begin
            if (gx == XB'(W - 1)) begin
                gx <= '0;
                gy <= (gy == YB'(H - 1)) ? '0 : gy + 1'b1;
            end else begin
                gx <= gx + 1'b1;
            end
        end
    end

    assign bus.clr_x     = gx;
    assign bus.clr_y     = gy;
    assign bus.clr_color = clr_col_v;
    assign bus.clr_valid = gen_valid_v;
    assign bus.clr_last  = (gx == XB'(W - 1)) && (gy == YB'(H - 1));

    function automatic void push_clear();
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                exp_q.push_back('{pix: {XB'(x), YB'(y), clr_col_v}, clr: 1'b1});
            end
        end
        clr_out += NPIX;
    endfunction

    // Scoreboard: compare every fb handshake with the head of the model queue.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            clr_out = 0;
            if (AUTO_CLR) push_clear();
        end else begin
            if (bus.fb_valid && bus.fb_ready) begin
                total++;
                assert (exp_q.size() > 0) else begin
                    bad++;
                    $error("FAIL fb_extra got=%0h want=none", {bus.fb_x, bus.fb_y, bus.fb_color});
                end
                if (exp_q.size() > 0) begin
                    e_m = exp_q.pop_front();
                    total++;
                    assert ({bus.fb_x, bus.fb_y, bus.fb_color} === e_m.pix) else begin
                        bad++;
                        $error("FAIL fb_pixel got=%0h want=%0h", {bus.fb_x, bus.fb_y, bus.fb_color}, e_m.pix);
                    end
                    if (e_m.clr) clr_out--;
                end
            end
            if (bus.draw_valid && bus.draw_ready)
                exp_q.push_back('{pix: {bus.draw_x, bus.draw_y, bus.draw_color}, clr: 1'b0});
            if (bus.clear_req && clr_out == 0) push_clear();
            if (bus.clear_done) begin
                done_cnt++;
                total++;
                assert ({gx, gy} === {XB'(W - 1), YB'(H - 1)}) else begin
                    bad++;
                    $error("FAIL clear_done_pos got=%0h want=%0h", {gx, gy}, {XB'(W - 1), YB'(H - 1)});
                end
            end
            if (bus.clr_reset) rst_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while ((clr_out != 0 || exp_q.size() != 0) && n < maxc) begin
            tick();
            n++;
        end
        chk("idle_reached", 32'((clr_out == 0) && (exp_q.size() == 0)), 32'd1);
    endtask

    task automatic wait_fb(input int x, input int y, input int maxc);
        int n = 0;
        while (!(bus.fb_valid && bus.fb_x == XB'(x) && bus.fb_y == YB'(y)) && n < maxc) begin
            tick();
            n++;
        end
        chk("fb_reached", {16'd0, 1'b0, bus.fb_valid, bus.fb_x, bus.fb_y, 11'd0},
            {16'd0, 1'b0, 1'b1, XB'(x), YB'(y), 11'd0});
    endtask

    int d0;
    int r0;

    initial begin
        reset = 1'b1;
        bus.clear_req  = 1'b0;
        bus.draw_valid = 1'b0;
        bus.draw_x     = '0;
        bus.draw_y     = '0;
        bus.draw_color = '0;
        bus.fb_ready   = 1'b1;
        gen_valid_v    = 1'b1;
        clr_col_v      = 12'h000;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_fb_valid", 32'(bus.fb_valid), 32'd0);
        chk("rst_fb_pix", 32'({bus.fb_x, bus.fb_y, bus.fb_color}), 32'd0);
        chk("rst_clear_done", 32'(bus.clear_done), 32'd0);
        chk("rst_clear_busy", 32'(bus.clear_busy), 32'(AUTO_CLR));
        reset = 1'b0;
        wait_idle(60);

        // Draw-only: one-cycle latency, order preserved
        bus.draw_valid = 1'b1;
        bus.draw_x = 2'd1; bus.draw_y = 1'd0; bus.draw_color = 12'hABC;
        #2 chk("draw_ready_1", 32'(bus.draw_ready), 32'd1);
        chk("draw_busy", 32'(bus.clear_busy), 32'd0);
        tick();
        chk("draw_out_1", 32'({bus.fb_valid, bus.fb_x, bus.fb_y, bus.fb_color}), 32'({1'b1, 2'd1, 1'd0, 12'hABC}));
        bus.draw_x = 2'd2; bus.draw_y = 1'd1; bus.draw_color = 12'h123;
        tick();
        bus.draw_valid = 1'b0;
        chk("draw_out_2", 32'({bus.fb_valid, bus.fb_x, bus.fb_y, bus.fb_color}), 32'({1'b1, 2'd2, 1'd1, 12'h123}));
        tick();
        chk("draw_drained", 32'(bus.fb_valid), 32'd0);

        // Clear sequence timing
        d0 = done_cnt; r0 = rst_cnt;
        bus.clear_req = 1'b1;
        #2 chk("clr_c0_busy", 32'(bus.clear_busy), 32'd0);
        tick();
        bus.clear_req = 1'b0;
        #2 chk("clr_c1_rst", 32'(bus.clr_reset), 32'd0);
        chk("clr_c1_draw_ready", 32'(bus.draw_ready), 32'd0);
        tick();
        #2 chk("clr_c2_rst", 32'(bus.clr_reset), 32'd1);
        chk("clr_c2_busy", 32'(bus.clear_busy), 32'd1);
        tick();
        #2 chk("clr_c3_rst", 32'(bus.clr_reset), 32'd0);
        chk("clr_c3_inc_skip", 32'(bus.clr_inc), 32'd0);
        tick();
        #2 chk("clr_c4_inc", 32'(bus.clr_inc), 32'd1);
        wait_idle(40);
        chk("clr_done_cnt", 32'(done_cnt), 32'(d0 + 1));
        chk("clr_rst_cnt", 32'(rst_cnt), 32'(r0 + 1));
        chk("clr_end_busy", 32'(bus.clear_busy), 32'd0);

        // Backpressure at (2,0)
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        wait_fb(2, 0, 40);
        bus.fb_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #2 chk("bp_hold", 32'({bus.fb_valid, bus.fb_x, bus.fb_y, bus.clr_inc}), 32'({1'b1, 2'd2, 1'd0, 1'b0}));
            tick();
        end
        bus.fb_ready = 1'b1;
        tick();
        chk("bp_next", 32'({bus.fb_valid, bus.fb_x, bus.fb_y}), 32'({1'b1, 2'd3, 1'd0}));
        wait_idle(40);

        // Preemption of a held draw stream
        d0 = done_cnt;
        bus.draw_valid = 1'b1;
        bus.draw_x = 2'd3; bus.draw_y = 1'd1; bus.draw_color = 12'h5A5;
        #2 chk("pre_draw_ready", 32'(bus.draw_ready), 32'd1);
        tick();
        bus.draw_x = 2'd0; bus.draw_y = 1'd1; bus.draw_color = 12'h777;
        bus.clear_req = 1'b1;
        #2 chk("pre_req_blocks", 32'(bus.draw_ready), 32'd0);
        tick();
        bus.clear_req = 1'b0;
        begin
            int n = 0;
            #2;
            while (!bus.draw_ready && n < 40) begin
                tick();
                #2;
                n++;
            end
        end
        chk("pre_ready_back", 32'(bus.draw_ready), 32'd1);
        chk("pre_done_cnt", 32'(done_cnt), 32'(d0 + 1));
        tick();
        bus.draw_valid = 1'b0;
        wait_idle(20);

        // clear_req during CLR_RUN is ignored
        d0 = done_cnt; r0 = rst_cnt;
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        wait_fb(1, 0, 40);
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        wait_idle(40);
        repeat (10) tick();
        chk("ign_done_cnt", 32'(done_cnt), 32'(d0 + 1));
        chk("ign_rst_cnt", 32'(rst_cnt), 32'(r0 + 1));

        // Reset at the third clear pixel
        clr_col_v = 12'h3C3;
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        wait_fb(2, 0, 40);
        r0 = rst_cnt;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_fb_valid", 32'(bus.fb_valid), 32'd0);
        chk("mid_rst_busy", 32'(bus.clear_busy), 32'(AUTO_CLR));
        wait_idle(60);
        chk("mid_rst_auto", 32'(rst_cnt), 32'(r0 + int'(AUTO_CLR)));

        // Randomized traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            bus.fb_ready   = ($urandom_range(3) != 0);
            bus.draw_valid = ($urandom_range(1) != 0);
            bus.draw_x     = XB'($urandom_range(W - 1));
            bus.draw_y     = YB'($urandom_range(H - 1));
            bus.draw_color = PB'($urandom);
            gen_valid_v    = ($urandom_range(4) != 0);
            if (clr_out == 0 && $urandom_range(29) == 0) begin
                clr_col_v     = PB'($urandom);
                bus.clear_req = 1'b1;
            end else begin
                bus.clear_req = 1'b0;
            end
            #2;
            if (bus.clear_req) chk("rnd_req_blocks", 32'(bus.draw_ready), 32'd0);
            tick();
        end
        bus.clear_req  = 1'b0;
        bus.draw_valid = 1'b0;
        bus.fb_ready   = 1'b1;
        gen_valid_v    = 1'b1;
        wait_idle(100);
        chk("final_busy", 32'(bus.clear_busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gfx_fb_write_arb.md
Name: gfx_fb_write_arb

Overview:
- Sequences the framebuffer clear generator and shares the single framebuffer pixel-write port between it and the drawing pipeline.
- On a clear request, stalls the draw stream, resets and restarts the clear generator, forwards every clear pixel, then hands the port back to the draw stream.
- Sits between the clear generator, the draw pipeline and the framebuffer write path.
- The output is a one-entry registered stage with valid/ready backpressure.

Parameters:
- FB_WIDTH, 640, framebuffer width in pixels; FB_X_BITS = $clog2(FB_WIDTH)
- FB_HEIGHT, 480, framebuffer height in pixels; FB_Y_BITS = $clog2(FB_HEIGHT)
- PIXEL_BITS, 12, pixel color width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- clear_req  in  1  one-cycle request to clear the framebuffer
- clear_busy  out  1  high while not in DRAW state
- clear_done  out  1  one-cycle pulse when the last clear pixel is accepted into the output stage
- clr_reset  out  1  reset to the clear generator
- clr_inc  out  1  advance the clear generator (current pixel consumed)
- clr_x  in  FB_X_BITS  clear pixel x
- clr_y  in  FB_Y_BITS  clear pixel y
- clr_color  in  PIXEL_BITS  clear pixel color
- clr_valid  in  1  clear pixel valid
- clr_last  in  1  current clear pixel is the final one
- draw_valid  in  1  draw pixel valid
- draw_ready  out  1  draw pixel accepted when high with draw_valid
- draw_x, draw_y, draw_color  in  FB_X_BITS / FB_Y_BITS / PIXEL_BITS  draw pixel
- fb_valid  out  1  output pixel valid
- fb_ready  in  1  framebuffer accepts output pixel
- fb_x, fb_y, fb_color  out  FB_X_BITS / FB_Y_BITS / PIXEL_BITS  output pixel

Behaviour:
- Reset values:
  - state DRAW; fb_valid 0; fb_x/fb_y/fb_color 0; pending 0.
  - clear_busy 0, clear_done 0, clr_reset 0.
- load = !fb_valid | fb_ready (combinational).
  - On load, the output register captures the selected source's pixel and fb_valid <= that source's handshake.
  - If nothing is transferred, fb_valid <= 0.
- DRAW:
  - draw_ready = load & !pending & !clear_req (combinational).
  - A draw transfer loads the output register; latency is 1 cycle to fb_valid.
  - clear_req sets pending. With pending set, the next cycle transitions to CLR_RST.
  - A draw pixel already in the output register drains normally, so ordering is preserved.
  - clr_inc = 0.
- CLR_RST:
  - clr_reset = 1 for exactly one cycle; pending cleared; next state CLR_RUN. draw_ready = 0.
- CLR_RUN:
  - clr_inc = clr_valid & load; a clear transfer loads the output register.
  - The cycle immediately after CLR_RST is not a transfer, even if clr_valid is stale-high.
  - Transfer with clr_last = 1: clear_done pulses that cycle and the next state is DRAW.
  - No clr_inc is issued after the last transfer.
- clear_busy = (state != DRAW).
- clear_req while in CLR_RST or CLR_RUN is ignored (not queued).
- clear_req on the same cycle as a DRAW draw transfer: the request wins and no draw transfer occurs.
- fb_ready low stalls both sources: no clr_inc and no draw_ready while the output register is full and not draining.
- reset mid-clear: return to DRAW and drop the output register contents (fb_valid 0).
  - The clear generator is not resumed; software reissues clear_req.

Optional Feature:
- GFX_FB_ARB_CLEAR_ON_RESET_EN defined: the reset state is CLR_RST, so a full clear runs automatically after reset.
  - clear_busy = 1 from the first cycle after reset until clear_done.
- Not defined: the reset state is DRAW and clears happen only on clear_req.

Test Plan (FB_WIDTH=4, FB_HEIGHT=2, clear generator instantiated):
- Draw-only: fb_ready=1, draw pixels (1,0,0xABC),(2,1,0x123) -> same pixels on fb_* one cycle later, in order; clear_busy=0.
- Clear: pulse clear_req, fb_ready=1 -> clr_reset 1 cycle; 8 fb pixels (0,0)..(3,1) with color 0; clear_done pulses on the (3,1) transfer; DRAW resumes after.
- Backpressure: during clear, hold fb_ready=0 for 5 cycles at (2,0) -> fb_* holds (2,0), clr_inc=0; release -> continues at (3,0), no dropped or duplicated pixel.
- Preemption: draw_valid held high, clear_req asserted -> draw_ready low the same cycle; the in-flight draw pixel exits before (0,0); draw_ready returns after clear_done.
- Clear_req during CLR_RUN -> ignored; exactly 8 clear pixels and one clear_done.
- Reset at the 3rd clear pixel -> fb_valid=0 next cycle, state DRAW. With GFX_FB_ARB_CLEAR_ON_RESET_EN, a fresh 8-pixel clear starts with no clear_req.
